// File: rtl/bounce_scheduler.sv
// Frame-synchronous bounce controller: on each eligible frame tick one shared
// bounce/clamp datapath sweeps every sprite, x axis then y axis, one axis per cycle.
module bounce_scheduler #(
  parameter int N_SPR     = 4,
  parameter int CORDW     = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int SPR_SIZE  = 200,
  parameter int SPD_INIT  = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CORDW-1:0]       sx,
  input  logic [CORDW-1:0]       sy,
  input  logic                   pause,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_idx,
  input  logic [CORDW-1:0]       cfg_x,
  input  logic [CORDW-1:0]       cfg_y,
  input  logic [CORDW-1:0]       cfg_spd,
  output logic [N_SPR*CORDW-1:0] pos_x,
  output logic [N_SPR*CORDW-1:0] pos_y,
  output logic                   busy,
  output logic                   upd_done,
  output logic                   overrun
);

  localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int SW = CORDW + 2;

  typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, DONE} state_t;

  state_t         state, state_n;
  logic [IW-1:0]  idx, idx_n;
  logic [DW-1:0]  div;
  logic           frame_q;
  logic           eligible;

  logic [CORDW-1:0] px  [N_SPR];
  logic [CORDW-1:0] py  [N_SPR];
  logic [CORDW-1:0] spd [N_SPR];
  logic [N_SPR-1:0] dx, dy;

  logic             cfg_ok;
  logic [IW-1:0]    cfg_sel;
  logic             cfg_hit;

  logic [CORDW-1:0] cur_p, cur_s, new_p;
  logic             cur_d, new_d;
  logic [SW-1:0]    lim, reach;

  assign eligible = frame_q && (div == '0);
  assign busy     = (state != IDLE);
  assign upd_done = (state == DONE);

  assign cfg_ok  = cfg_we && (int'(cfg_idx) < N_SPR);
  assign cfg_sel = cfg_idx[IW-1:0];
  assign cfg_hit = cfg_ok && (cfg_sel == idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= 1'b0;
      div     <= '0;
      overrun <= 1'b0;
    end else begin
      frame_q <= (sy == CORDW'(V_RES)) && (sx == '0);
      if (frame_q)
        div <= (div == DW'(FRAME_DIV - 1)) ? '0 : div + 1'b1;
      if (eligible && busy)
        overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (eligible && !pause) begin
          state_n = UPD_X;
          idx_n   = '0;
        end
      end
      UPD_X: state_n = UPD_Y;
      UPD_Y: begin
        if (idx == IW'(N_SPR - 1)) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = UPD_X;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Shared datapath: selects the axis owned by the current state and applies bounce/clamp.
  always_comb begin
    cur_p = (state == UPD_Y) ? py[idx] : px[idx];
    cur_d = (state == UPD_Y) ? dy[idx] : dx[idx];
    cur_s = spd[idx];
    lim   = (state == UPD_Y) ? SW'(V_RES) : SW'(H_RES);
    reach = SW'(cur_p) + SW'(SPR_SIZE) + SW'(cur_s);
    new_p = cur_p;
    new_d = cur_d;
    if (!cur_d) begin
      if (reach >= lim - SW'(1)) begin
        new_p = CORDW'(lim - SW'(SPR_SIZE) - SW'(1));
        new_d = 1'b1;
      end else begin
        new_p = cur_p + cur_s;
      end
    end else begin
      if (cur_p < cur_s) begin
        new_p = '0;
        new_d = 1'b0;
      end else begin
        new_p = cur_p - cur_s;
      end
    end
  end

  // A config write to the sprite being committed overrides that axis for this sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_SPR; k++) begin
        px[k]  <= '0;
        py[k]  <= '0;
        spd[k] <= CORDW'(SPD_INIT);
      end
      dx <= '0;
      dy <= '0;
    end else begin
      if (state == UPD_X && !cfg_hit) begin
        px[idx] <= new_p;
        dx[idx] <= new_d;
      end
      if (state == UPD_Y && !cfg_hit) begin
        py[idx] <= new_p;
        dy[idx] <= new_d;
      end
      if (cfg_ok) begin
        px[cfg_sel]  <= cfg_x;
        py[cfg_sel]  <= cfg_y;
        spd[cfg_sel] <= cfg_spd;
      end
    end
  end

  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int k = 0; k < N_SPR; k++) begin
      pos_x[k*CORDW +: CORDW] = px[k];
      pos_y[k*CORDW +: CORDW] = py[k];
    end
  end

endmodule

// File: tb/tb_bounce_scheduler.sv
// Self-checking bench for bounce_scheduler: frames are driven as single scan ticks and
// compared against a sweep-level sprite motion model.
module tb_bounce_scheduler;

  localparam int N   = 4;
  localparam int CW  = 10;
  localparam int H   = 640;
  localparam int V   = 480;
  localparam int SZ  = 200;
  localparam int SPD = 2;
  localparam int FD  = 3;

  logic            clk;
  logic            rst_n;
  logic [CW-1:0]   sx, sy;
  logic            pause;
  logic            cfg_we;
  logic [2:0]      cfg_idx;
  logic [CW-1:0]   cfg_x, cfg_y, cfg_spd;
  logic [N*CW-1:0] pos_x, pos_y;
  logic            busy, upd_done, overrun;

  int checks   = 0;
  int failures = 0;

  int mx[N], my[N], mdx[N], mdy[N], ms[N];
  int fc;
  int ovr;
  int fnum;

  bounce_scheduler #(
    .N_SPR(N), .CORDW(CW), .H_RES(H), .V_RES(V),
    .SPR_SIZE(SZ), .SPD_INIT(SPD), .FRAME_DIV(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy), .pause(pause),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_spd(cfg_spd),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .upd_done(upd_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One axis of motion: move by s toward the current direction, bounce at the walls.
  function automatic void step(input int p, input int d, input int s, input int lim,
                               output int np, output int nd);
    np = p;
    nd = d;
    if (d == 0) begin
      if (p + SZ + s >= lim - 1) begin
        np = lim - SZ - 1;
        nd = 1;
      end else begin
        np = p + s;
      end
    end else begin
      if (p < s) begin
        np = 0;
        nd = 0;
      end else begin
        np = p - s;
      end
    end
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      mx[j] = 0; my[j] = 0; mdx[j] = 0; mdy[j] = 0; ms[j] = SPD;
    end
    fc  = 0;
    ovr = 0;
  endtask

  task automatic check_positions(input string what);
    for (int j = 0; j < N; j++) begin
      check($sformatf("%s f%0d x%0d", what, fnum, j), 32'(pos_x[j*CW +: CW]), 32'(mx[j]));
      check($sformatf("%s f%0d y%0d", what, fnum, j), 32'(pos_y[j*CW +: CW]), 32'(my[j]));
    end
  endtask

  // One frame tick. conf_k selects the post-launch cycle carrying a config write
  // (0 = none); dbl injects three extra frame ticks during the sweep.
  task automatic applyStimulus(input bit pz, input int conf_k, input int c_idx,
                               input int cx, input int cy, input int cs, input bit dbl);
    bit launch;
    int busy_cnt, done_cnt, done_k, j, np, nd;
    bit hit;
    launch = ((fc % FD) == 0) && !pz;
    fc++;
    pause  = pz;
    cfg_we = 1'b0;
    sx = '0;
    sy = CW'(V);
    @(posedge clk); @(negedge clk);
    sy = '0;
    sx = CW'(5);
    busy_cnt = 0; done_cnt = 0; done_k = 0;
    for (int k = 1; k <= 2*N + 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (busy) busy_cnt++;
      if (upd_done) begin done_cnt++; done_k = k; end
      cfg_we = 1'b0;
      sy = '0;
      sx = CW'(5);
      if (launch && k <= 2*N) begin
        j   = (k - 1) / 2;
        hit = (k == conf_k) && (c_idx == j);
        if (!hit) begin
          if (k % 2 == 1) begin
            step(mx[j], mdx[j], ms[j], H, np, nd); mx[j] = np; mdx[j] = nd;
          end else begin
            step(my[j], mdy[j], ms[j], V, np, nd); my[j] = np; mdy[j] = nd;
          end
        end
      end
      if (k == conf_k) begin
        cfg_we  = 1'b1;
        cfg_idx = 3'(c_idx);
        cfg_x   = CW'(cx);
        cfg_y   = CW'(cy);
        cfg_spd = CW'(cs);
        if (c_idx < N) begin
          mx[c_idx] = cx; my[c_idx] = cy; ms[c_idx] = cs;
        end
      end
      if (dbl && (k == 1 || k == 3 || k == 5)) begin
        if (launch && (fc % FD) == 0) ovr = 1;
        fc++;
        sy = CW'(V);
        sx = '0;
      end
    end
    cfg_we = 1'b0;
    pause  = 1'b0;
    check($sformatf("busy_cycles f%0d", fnum), 32'(busy_cnt), launch ? 32'(2*N + 1) : 32'd0);
    check($sformatf("upd_done_count f%0d", fnum), 32'(done_cnt), launch ? 32'd1 : 32'd0);
    if (launch)
      check($sformatf("upd_done_cycle f%0d", fnum), 32'(done_k), 32'(2*N + 1));
    check($sformatf("overrun f%0d", fnum), 32'(overrun), 32'(ovr));
    checkOutput("frame");
    fnum++;
  endtask

  task automatic checkOutput(input string what);
    check_positions(what);
  endtask

  task automatic idle_until_eligible();
    while ((fc % FD) != 0) applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    int cidx, ck;
    rst_n = 1'b0; sx = '0; sy = '0; pause = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_spd = '0;
    fnum = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset upd_done", 32'(upd_done), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    checkOutput("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Plain first sweep, then a right-wall bounce on sprite 0 across two sweeps.
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 2, 0, 438, 100, 2, 1'b0);
    idle_until_eligible();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
    check("bounce x439", 32'(pos_x[0 +: CW]), 32'd439);
    idle_until_eligible();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
    check("bounce x437", 32'(pos_x[0 +: CW]), 32'd437);

    // Paused eligible frame is skipped; the next eligible frame sweeps.
    idle_until_eligible();
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 1'b0);
    idle_until_eligible();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);

    // Config write colliding with sprite 2's x commit.
    idle_until_eligible();
    applyStimulus(1'b0, 5, 2, 50, 120, 3, 1'b0);
    check("collide x50", 32'(pos_x[2*CW +: CW]), 32'd50);

    // Near-left-wall sprite plus an ignored out-of-range index.
    applyStimulus(1'b0, 3, 1, 1, 278, 2, 1'b0);
    applyStimulus(1'b0, 4, 6, 300, 200, 9, 1'b0);

    for (int f = 0; f < 30; f++) begin
      ck   = int'($urandom_range(0, 2*N + 2));
      cidx = ($urandom_range(0, 1) == 1 && ck > 0) ? (ck - 1) / 2 : int'($urandom_range(0, 7));
      if (cidx > 7) cidx = 7;
      applyStimulus($urandom_range(0, 4) == 0, ck, cidx,
                    int'($urandom_range(0, H - SZ - 1)), int'($urandom_range(0, V - SZ - 1)),
                    int'($urandom_range(0, 9)), 1'b0);
    end

    // Frame ticks arriving during a sweep: third one is eligible and sets overrun.
    idle_until_eligible();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b1);
    check("overrun set", 32'(overrun), 32'd1);

    // Reset in the middle of sprite 1's y commit.
    idle_until_eligible();
    sx = '0;
    sy = CW'(V);
    @(posedge clk); @(negedge clk);
    sy = '0;
    sx = CW'(5);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst upd_done", 32'(upd_done), 32'd0);
    check("midrst overrun", 32'(overrun), 32'd0);
    checkOutput("midrst");
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
    check("after rst x0", 32'(pos_x[0 +: CW]), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
